// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_pkg
// Purpose  : Shared types and constants for the ID/EX pipeline register:
//            ALU command codes, instruction mode encodings, default widths
//            and the packed control-group record.
// Options  : ID_EX_FWD_INFO_EN (used by the interface and top, not here)
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_reg_pkg;

  // Default widths for the PC / operand datapath and register addresses
  localparam int c_DATA_WIDTH_DEF     = 32;
  localparam int c_REG_ADDR_WIDTH_DEF = 4;

  // ALU command codes carried on Sigs_Control
  localparam logic [3:0] c_ALU_NOP = 4'd0;
  localparam logic [3:0] c_ALU_MOV = 4'd1;
  localparam logic [3:0] c_ALU_ADD = 4'd2;
  localparam logic [3:0] c_ALU_ADC = 4'd3;
  localparam logic [3:0] c_ALU_SUB = 4'd4;
  localparam logic [3:0] c_ALU_SBC = 4'd5;
  localparam logic [3:0] c_ALU_AND = 4'd6;
  localparam logic [3:0] c_ALU_ORR = 4'd7;
  localparam logic [3:0] c_ALU_EOR = 4'd8;
  localparam logic [3:0] c_ALU_MVN = 4'd9;

  // Instruction mode field encodings from the decoder
  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10
  } mode_e;

  // Control group: everything that can cause a side effect in EX/MEM/WB.
  // A bubble or flush zeroes this whole record.
  typedef struct packed {
    logic       valid;
    logic [3:0] sigs_control;
    logic       mem_read;
    logic       mem_write;
    logic       write_back;
    logic       status_write;
    logic       branch_taken;
    logic       immediate;
  } ctrl_t;

  localparam int c_CTRL_W = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_if
// Purpose  : Bundle of ID-side inputs and EX-side registered outputs of the
//            ID/EX pipeline register. The stage register uses the slave
//            modport; the decode side / bench uses the master modport.
// Options  : ID_EX_FWD_INFO_EN adds Src1/Src2/Two_Src forwarding fields.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_reg_if
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = c_REG_ADDR_WIDTH_DEF
);

  logic                      i_Flush;
  logic                      i_Freeze;
  logic                      i_Valid;
  logic [DATA_WIDTH-1:0]     i_PC;
  logic [3:0]                i_Sigs_Control;
  logic                      i_Sig_Memory_Read_Enable;
  logic                      i_Sig_Memory_Write_Enable;
  logic                      i_Sig_Write_Back_Enable;
  logic                      i_Sig_Status_Write_Enable;
  logic                      i_Sig_Branch_Taken;
  logic                      i_Immediate;
  logic [DATA_WIDTH-1:0]     i_Val_Rn;
  logic [DATA_WIDTH-1:0]     i_Val_Rm;
  logic [11:0]               i_Shift_Operand;
  logic [23:0]               i_Signed_Imm_24;
  logic [REG_ADDR_WIDTH-1:0] i_Dest;
  logic                      i_Carry;

  logic                      o_Valid;
  logic [DATA_WIDTH-1:0]     o_PC;
  logic [3:0]                o_Sigs_Control;
  logic                      o_Sig_Memory_Read_Enable;
  logic                      o_Sig_Memory_Write_Enable;
  logic                      o_Sig_Write_Back_Enable;
  logic                      o_Sig_Status_Write_Enable;
  logic                      o_Sig_Branch_Taken;
  logic                      o_Immediate;
  logic [DATA_WIDTH-1:0]     o_Val_Rn;
  logic [DATA_WIDTH-1:0]     o_Val_Rm;
  logic [11:0]               o_Shift_Operand;
  logic [23:0]               o_Signed_Imm_24;
  logic [REG_ADDR_WIDTH-1:0] o_Dest;
  logic                      o_Carry;

`ifdef ID_EX_FWD_INFO_EN
  logic [REG_ADDR_WIDTH-1:0] i_Src1;
  logic [REG_ADDR_WIDTH-1:0] i_Src2;
  logic                      i_Two_Src;
  logic [REG_ADDR_WIDTH-1:0] o_Src1;
  logic [REG_ADDR_WIDTH-1:0] o_Src2;
  logic                      o_Two_Src;
`endif

  modport master (
    output i_Flush, i_Freeze, i_Valid, i_PC, i_Sigs_Control,
           i_Sig_Memory_Read_Enable, i_Sig_Memory_Write_Enable,
           i_Sig_Write_Back_Enable, i_Sig_Status_Write_Enable,
           i_Sig_Branch_Taken, i_Immediate, i_Val_Rn, i_Val_Rm,
           i_Shift_Operand, i_Signed_Imm_24, i_Dest, i_Carry,
    input  o_Valid, o_PC, o_Sigs_Control,
           o_Sig_Memory_Read_Enable, o_Sig_Memory_Write_Enable,
           o_Sig_Write_Back_Enable, o_Sig_Status_Write_Enable,
           o_Sig_Branch_Taken, o_Immediate, o_Val_Rn, o_Val_Rm,
           o_Shift_Operand, o_Signed_Imm_24, o_Dest, o_Carry
`ifdef ID_EX_FWD_INFO_EN
  , output i_Src1, i_Src2, i_Two_Src
  , input  o_Src1, o_Src2, o_Two_Src
`endif
  );

  modport slave (
    input  i_Flush, i_Freeze, i_Valid, i_PC, i_Sigs_Control,
           i_Sig_Memory_Read_Enable, i_Sig_Memory_Write_Enable,
           i_Sig_Write_Back_Enable, i_Sig_Status_Write_Enable,
           i_Sig_Branch_Taken, i_Immediate, i_Val_Rn, i_Val_Rm,
           i_Shift_Operand, i_Signed_Imm_24, i_Dest, i_Carry,
    output o_Valid, o_PC, o_Sigs_Control,
           o_Sig_Memory_Read_Enable, o_Sig_Memory_Write_Enable,
           o_Sig_Write_Back_Enable, o_Sig_Status_Write_Enable,
           o_Sig_Branch_Taken, o_Immediate, o_Val_Rn, o_Val_Rm,
           o_Shift_Operand, o_Signed_Imm_24, o_Dest, o_Carry
`ifdef ID_EX_FWD_INFO_EN
  , input  i_Src1, i_Src2, i_Two_Src
  , output o_Src1, o_Src2, o_Two_Src
`endif
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg_pipe_reg_en.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_en
// Purpose  : Generic pipeline register field group. Priority on each rising
//            edge: synchronous active-low reset, then synchronous clear,
//            then load when enabled; otherwise hold.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_en #(
  parameter int WIDTH = 8
) (
  input  wire logic             i_Clock,
  input  wire logic             i_Reset,
  input  wire logic             i_Clear,
  input  wire logic             i_Enable,
  input  wire logic [WIDTH-1:0] i_D,
  output logic      [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] r_q;

  // Reset beats clear beats enable; a disabled register simply holds
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_q <= '0;
    end else if (i_Clear) begin
      r_q <= '0;
    end else if (i_Enable) begin
      r_q <= i_D;
    end
  end

  assign o_Q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register. Captures decoded control, operands,
//            PC and destination with one cycle of latency. Flush (branch
//            taken) inserts a bubble and overrides Freeze (hazard stall),
//            which holds every field. A bubble entering from ID never
//            carries a side-effect enable into EX.
// Options  : ID_EX_FWD_INFO_EN registers Src1/Src2/Two_Src for forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = c_REG_ADDR_WIDTH_DEF
) (
  input  wire logic          i_Clock,
  input  wire logic          i_Reset,
  id_ex_stage_reg_if.slave   bus
);

  localparam int c_DP_W = 3 * DATA_WIDTH + 12 + 24 + REG_ADDR_WIDTH + 1;

  logic              w_clear;
  logic              w_enable;
  ctrl_t             w_ctrl_d;
  ctrl_t             w_ctrl_q;
  logic [c_DP_W-1:0] w_dp_d;
  logic [c_DP_W-1:0] w_dp_q;

  // Flush wins over freeze because clear has priority inside pipe_reg_en
  assign w_clear  = bus.i_Flush;
  assign w_enable = ~bus.i_Freeze;

  // Control group: a bubble loads all-zero so nothing downstream fires
  always_comb begin
    w_ctrl_d = '0;
    if (bus.i_Valid) begin
      w_ctrl_d.valid        = 1'b1;
      w_ctrl_d.sigs_control = bus.i_Sigs_Control;
      w_ctrl_d.mem_read     = bus.i_Sig_Memory_Read_Enable;
      w_ctrl_d.mem_write    = bus.i_Sig_Memory_Write_Enable;
      w_ctrl_d.write_back   = bus.i_Sig_Write_Back_Enable;
      w_ctrl_d.status_write = bus.i_Sig_Status_Write_Enable;
      w_ctrl_d.branch_taken = bus.i_Sig_Branch_Taken;
      w_ctrl_d.immediate    = bus.i_Immediate;
    end
  end

  pipe_reg_en #(.WIDTH(c_CTRL_W)) u_ctrl_reg (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (w_clear),
    .i_Enable (w_enable),
    .i_D      (w_ctrl_d),
    .o_Q      (w_ctrl_q)
  );

  assign bus.o_Valid                   = w_ctrl_q.valid;
  assign bus.o_Sigs_Control            = w_ctrl_q.sigs_control;
  assign bus.o_Sig_Memory_Read_Enable  = w_ctrl_q.mem_read;
  assign bus.o_Sig_Memory_Write_Enable = w_ctrl_q.mem_write;
  assign bus.o_Sig_Write_Back_Enable   = w_ctrl_q.write_back;
  assign bus.o_Sig_Status_Write_Enable = w_ctrl_q.status_write;
  assign bus.o_Sig_Branch_Taken        = w_ctrl_q.branch_taken;
  assign bus.o_Immediate               = w_ctrl_q.immediate;

  // Datapath group: copied regardless of i_Valid (don't-care on a bubble)
  assign w_dp_d = {bus.i_PC, bus.i_Val_Rn, bus.i_Val_Rm, bus.i_Shift_Operand,
                   bus.i_Signed_Imm_24, bus.i_Dest, bus.i_Carry};

  pipe_reg_en #(.WIDTH(c_DP_W)) u_dp_reg (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (w_clear),
    .i_Enable (w_enable),
    .i_D      (w_dp_d),
    .o_Q      (w_dp_q)
  );

  assign {bus.o_PC, bus.o_Val_Rn, bus.o_Val_Rm, bus.o_Shift_Operand,
          bus.o_Signed_Imm_24, bus.o_Dest, bus.o_Carry} = w_dp_q;

`ifdef ID_EX_FWD_INFO_EN
  localparam int c_FWD_W = 2 * REG_ADDR_WIDTH + 1;

  logic [c_FWD_W-1:0] w_fwd_d;
  logic [c_FWD_W-1:0] w_fwd_q;

  // Forwarding group: zeroed on a bubble so the hazard unit sees no sources
  assign w_fwd_d = bus.i_Valid ? {bus.i_Src1, bus.i_Src2, bus.i_Two_Src}
                               : '0;

  pipe_reg_en #(.WIDTH(c_FWD_W)) u_fwd_reg (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (w_clear),
    .i_Enable (w_enable),
    .i_D      (w_fwd_d),
    .o_Q      (w_fwd_q)
  );

  assign {bus.o_Src1, bus.o_Src2, bus.o_Two_Src} = w_fwd_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Purpose  : Self-checking bench for id_ex_stage_reg. A behavioural model
//            predicts the registered outputs for each driven cycle and
//            queues them; after the edge the queue head is compared with
//            the DUT, alongside directed checks and the bubble invariant.
// Options  : ID_EX_FWD_INFO_EN exercises the forwarding fields.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct packed {
    logic          valid;
    logic [3:0]    ctrl;
    logic          mr;
    logic          mw;
    logic          wb;
    logic          st;
    logic          br;
    logic          imm;
    logic [DW-1:0] pc;
    logic [DW-1:0] rn;
    logic [DW-1:0] rm;
    logic [11:0]   shift;
    logic [23:0]   imm24;
    logic [AW-1:0] dest;
    logic          carry;
`ifdef ID_EX_FWD_INFO_EN
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          two;
`endif
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t model;
  exp_t sb_q[$];

  id_ex_stage_reg_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) intf ();

  id_ex_stage_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .i_Clock (clk),
    .i_Reset (rst_n),
    .bus     (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector, reports any miscompare
  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.valid = intf.o_Valid;
    o.ctrl  = intf.o_Sigs_Control;
    o.mr    = intf.o_Sig_Memory_Read_Enable;
    o.mw    = intf.o_Sig_Memory_Write_Enable;
    o.wb    = intf.o_Sig_Write_Back_Enable;
    o.st    = intf.o_Sig_Status_Write_Enable;
    o.br    = intf.o_Sig_Branch_Taken;
    o.imm   = intf.o_Immediate;
    o.pc    = intf.o_PC;
    o.rn    = intf.o_Val_Rn;
    o.rm    = intf.o_Val_Rm;
    o.shift = intf.o_Shift_Operand;
    o.imm24 = intf.o_Signed_Imm_24;
    o.dest  = intf.o_Dest;
    o.carry = intf.o_Carry;
`ifdef ID_EX_FWD_INFO_EN
    o.src1  = intf.o_Src1;
    o.src2  = intf.o_Src2;
    o.two   = intf.o_Two_Src;
`endif
    return o;
  endfunction

  // Behavioural next-state: reset > flush > freeze > load
  function automatic exp_t predict(input exp_t cur);
    exp_t n;
    n = '0;
    if (!rst_n || intf.i_Flush) begin
      n = '0;
    end else if (intf.i_Freeze) begin
      n = cur;
    end else begin
      n.pc    = intf.i_PC;
      n.rn    = intf.i_Val_Rn;
      n.rm    = intf.i_Val_Rm;
      n.shift = intf.i_Shift_Operand;
      n.imm24 = intf.i_Signed_Imm_24;
      n.dest  = intf.i_Dest;
      n.carry = intf.i_Carry;
      if (intf.i_Valid) begin
        n.valid = 1'b1;
        n.ctrl  = intf.i_Sigs_Control;
        n.mr    = intf.i_Sig_Memory_Read_Enable;
        n.mw    = intf.i_Sig_Memory_Write_Enable;
        n.wb    = intf.i_Sig_Write_Back_Enable;
        n.st    = intf.i_Sig_Status_Write_Enable;
        n.br    = intf.i_Sig_Branch_Taken;
        n.imm   = intf.i_Immediate;
`ifdef ID_EX_FWD_INFO_EN
        n.src1  = intf.i_Src1;
        n.src2  = intf.i_Src2;
        n.two   = intf.i_Two_Src;
`endif
      end
    end
    return n;
  endfunction

  // Drive-side: push prediction, clock once, pop and compare
  task automatic step(input string tag);
    exp_t e;
    exp_t o;
    model = predict(model);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    o = observe();
    if (sb_q.size() == 0) begin
      check({"sb_empty_", tag}, 256'd1, 256'd0);
    end else begin
      e = sb_q.pop_front();
      check({"sb_", tag}, 256'(o), 256'(e));
    end
    check({"inv_", tag},
          256'(~o.valid & (o.mr | o.mw | o.wb | o.st | o.br)), 256'd0);
  endtask

  task automatic set_instr(input logic v, input logic [3:0] c,
                           input logic mr, input logic mw, input logic wb,
                           input logic st, input logic br, input logic im,
                           input logic [DW-1:0] pc, input logic [DW-1:0] rn,
                           input logic [DW-1:0] rm, input logic [AW-1:0] d);
    intf.i_Valid                   = v;
    intf.i_Sigs_Control            = c;
    intf.i_Sig_Memory_Read_Enable  = mr;
    intf.i_Sig_Memory_Write_Enable = mw;
    intf.i_Sig_Write_Back_Enable   = wb;
    intf.i_Sig_Status_Write_Enable = st;
    intf.i_Sig_Branch_Taken        = br;
    intf.i_Immediate               = im;
    intf.i_PC                      = pc;
    intf.i_Val_Rn                  = rn;
    intf.i_Val_Rm                  = rm;
    intf.i_Dest                    = d;
    intf.i_Shift_Operand           = rm[11:0];
    intf.i_Signed_Imm_24           = rn[23:0];
    intf.i_Carry                   = rn[0];
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model = '0;

    // Reset with every input driven high
    rst_n         = 1'b0;
    intf.i_Flush  = 1'b1;
    intf.i_Freeze = 1'b1;
    set_instr(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              '1, '1, '1, '1);
`ifdef ID_EX_FWD_INFO_EN
    intf.i_Src1    = '1;
    intf.i_Src2    = '1;
    intf.i_Two_Src = 1'b1;
`endif
    step("reset0");
    step("reset1");
    check("reset_valid", 256'(intf.o_Valid), 256'd0);
    check("reset_pc",    256'(intf.o_PC),    256'd0);

    // Plain load of an ADD
    rst_n         = 1'b1;
    intf.i_Flush  = 1'b0;
    intf.i_Freeze = 1'b0;
    set_instr(1'b1, c_ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
              32'h0000_0104, 32'h10, 32'h20, 4'd3);
    step("load_add");
    check("add_ctrl",  256'(intf.o_Sigs_Control),          256'd2);
    check("add_dest",  256'(intf.o_Dest),                  256'd3);
    check("add_wb",    256'(intf.o_Sig_Write_Back_Enable), 256'd1);
    check("add_valid", 256'(intf.o_Valid),                 256'd1);
    check("add_rn",    256'(intf.o_Val_Rn),                256'h10);
    check("add_rm",    256'(intf.o_Val_Rm),                256'h20);

    // Load STR, then freeze for three cycles while inputs change
    set_instr(1'b1, c_ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              32'h0000_0108, 32'h1000, 32'h4, 4'd5);
    step("load_str");
    intf.i_Freeze = 1'b1;
    set_instr(1'b1, c_ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              32'h0000_010C, 32'hAAAA_5555, 32'h1234_5678, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step("freeze");
      check("freeze_mw", 256'(intf.o_Sig_Memory_Write_Enable), 256'd1);
      check("freeze_pc", 256'(intf.o_PC), 256'h108);
    end
    intf.i_Freeze = 1'b0;
    step("release");
    check("release_pc",   256'(intf.o_PC),           256'h10C);
    check("release_ctrl", 256'(intf.o_Sigs_Control), 256'd4);

    // Flush together with freeze, LDR at the input
    intf.i_Flush  = 1'b1;
    intf.i_Freeze = 1'b1;
    set_instr(1'b1, c_ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
              32'h0000_0110, 32'h2000, 32'h8, 4'd7);
    step("flush_freeze");
    check("flush_valid", 256'(intf.o_Valid),                  256'd0);
    check("flush_mr",    256'(intf.o_Sig_Memory_Read_Enable), 256'd0);
    check("flush_wb",    256'(intf.o_Sig_Write_Back_Enable),  256'd0);
    check("flush_rn",    256'(intf.o_Val_Rn),                 256'd0);

    // Bubble from ID carrying stale enables
    intf.i_Flush  = 1'b0;
    intf.i_Freeze = 1'b0;
    set_instr(1'b0, c_ALU_ORR, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
              32'h0000_0114, 32'h33, 32'h44, 4'd2);
    step("bubble");
    check("bubble_wb",   256'(intf.o_Sig_Write_Back_Enable),   256'd0);
    check("bubble_st",   256'(intf.o_Sig_Status_Write_Enable), 256'd0);
    check("bubble_ctrl", 256'(intf.o_Sigs_Control),            256'd0);
    check("bubble_pc",   256'(intf.o_PC),                      256'h114);

    // Reset asserted during a freeze still clears
    set_instr(1'b1, c_ALU_EOR, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              32'h0000_0118, 32'h55, 32'h66, 4'd1);
    step("pre_rst");
    intf.i_Freeze = 1'b1;
    rst_n         = 1'b0;
    step("rst_in_freeze");
    check("rstfrz_valid", 256'(intf.o_Valid), 256'd0);
    check("rstfrz_dest",  256'(intf.o_Dest),  256'd0);
    rst_n         = 1'b1;
    intf.i_Freeze = 1'b0;

`ifdef ID_EX_FWD_INFO_EN
    // Forwarding source fields
    intf.i_Src1    = 4'd5;
    intf.i_Src2    = 4'd7;
    intf.i_Two_Src = 1'b1;
    step("fwd_load");
    check("fwd_src1", 256'(intf.o_Src1),    256'd5);
    check("fwd_src2", 256'(intf.o_Src2),    256'd7);
    check("fwd_two",  256'(intf.o_Two_Src), 256'd1);
    intf.i_Flush = 1'b1;
    step("fwd_flush");
    check("fwd_flush", 256'({intf.o_Src1, intf.o_Src2, intf.o_Two_Src}),
          256'd0);
    intf.i_Flush = 1'b0;
    intf.i_Valid = 1'b0;
    step("fwd_bubble");
    check("fwd_bubble", 256'({intf.o_Src1, intf.o_Src2, intf.o_Two_Src}),
          256'd0);
`endif

    // Mixed random traffic, scoreboard only
    for (int i = 0; i < 40; i++) begin
      intf.i_Flush  = ($urandom_range(0, 7) == 0);
      intf.i_Freeze = ($urandom_range(0, 3) == 0);
      set_instr(1'($urandom), 4'($urandom_range(0, 9)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, $urandom, $urandom, 4'($urandom));
`ifdef ID_EX_FWD_INFO_EN
      intf.i_Src1    = 4'($urandom);
      intf.i_Src2    = 4'($urandom);
      intf.i_Two_Src = 1'($urandom);
`endif
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
